// File: rtl/draw_menu_if.sv
// vga_if: VGA timing bundle passed through the menu overlay pipeline.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
    modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/draw_menu.sv
// draw_menu: two-stage button overlay with per-frame mouse sampling and a click/selection FSM.
module draw_menu #(
    parameter int          N_BTN        = 2,
    parameter int          BTN_X        = 412,
    parameter int          BTN_Y0       = 300,
    parameter int          BTN_W        = 200,
    parameter int          BTN_H        = 50,
    parameter int          BTN_GAP      = 20,
    parameter int          BORDER       = 2,
    parameter logic [11:0] BTN_COLOR    = 12'h0F0,
    parameter logic [11:0] HOVER_COLOR  = 12'h0C0,
    parameter logic [11:0] PRESS_COLOR  = 12'h080,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic        mouse_left,
    vga_if.in           vga_in,
    input  logic [11:0] rgb_i,
    vga_if.out          vga_out,
    output logic [11:0] rgb_o,
    output logic        sel_valid,
    output logic [1:0]  sel_idx,
    input  logic        sel_ready
);
    typedef enum logic [1:0] {IDLE, ARMED, BLOCKED} state_t;
    localparam logic [12:0] X0  = 13'(BTN_X);
    localparam logic [12:0] X1  = 13'(BTN_X + BTN_W);
    localparam logic [12:0] IX0 = 13'(BTN_X + BORDER);
    localparam logic [12:0] IX1 = 13'(BTN_X + BTN_W - BORDER);
    state_t      state_q, state_d;
    logic [1:0]  rst_sync_q;
    logic        rst_n;
    logic [10:0] hcount1_q, vcount1_q;
    logic        hblnk1_q, vblnk1_q, hsync1_q, vsync1_q;
    logic [11:0] rgb1_q, rgb_d, rgb_q;
    logic [3:0]  in_d, brd_d, in1_q, brd1_q, mhit;
    logic [11:0] mx_q, my_q;
    logic        ml_q, sample, sample_q;
    logic [1:0]  hover_idx, arm_q, arm_d, sel_idx_q;
    logic        hover_hit, sel_evt, press_px, hover_px, sel_valid_q;
    logic [12:0] px, py, mx, my;
    assign px = {2'b00, vga_in.hcount};
    assign py = {2'b00, vga_in.vcount};
    assign mx = {1'b0, mx_q};
    assign my = {1'b0, my_q};
    // Internal reset asserts immediately and releases two clocks after rst rises
    always_ff @(posedge clk or negedge rst)
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];
    for (genvar i = 0; i < 4; i++) begin : g_btn
        if (i < N_BTN) begin : g_on
            localparam logic [12:0] Y0  = 13'(BTN_Y0 + i * (BTN_H + BTN_GAP));
            localparam logic [12:0] Y1  = 13'(BTN_Y0 + i * (BTN_H + BTN_GAP) + BTN_H);
            localparam logic [12:0] IY0 = 13'(BTN_Y0 + i * (BTN_H + BTN_GAP) + BORDER);
            localparam logic [12:0] IY1 = 13'(BTN_Y0 + i * (BTN_H + BTN_GAP) + BTN_H - BORDER);
            assign in_d[i]  = px >= X0 && px < X1 && py >= Y0 && py < Y1;
            assign brd_d[i] = in_d[i] && !(px >= IX0 && px < IX1 && py >= IY0 && py < IY1);
            assign mhit[i]  = mx >= X0 && mx < X1 && my >= Y0 && my < Y1;
        end else begin : g_off
            assign in_d[i]  = 1'b0;
            assign brd_d[i] = 1'b0;
            assign mhit[i]  = 1'b0;
        end
    end
    assign sample = vga_in.vblnk && !vblnk1_q;
    always_comb begin
        hover_idx = 2'd0;
        for (int k = 3; k >= 0; k--) hover_idx = mhit[k] ? 2'(k) : hover_idx;
    end
    assign hover_hit = enable && |mhit;
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        sel_evt = 1'b0;
        if (sample_q)
            case (state_q)
                IDLE: if (ml_q) begin
                    state_d = hover_hit ? ARMED : BLOCKED;
                    arm_d   = hover_idx;
                end
                ARMED: if (!ml_q) begin
                    state_d = IDLE;
                    sel_evt = hover_hit && hover_idx == arm_q;
                end
                BLOCKED: state_d = ml_q ? BLOCKED : IDLE;
                default: state_d = IDLE;
            endcase
        if (!enable) begin
            state_d = IDLE;
            sel_evt = 1'b0;
        end
    end
    assign press_px = state_q == ARMED && in1_q[arm_q];
    assign hover_px = hover_hit && in1_q[hover_idx];
    assign rgb_d = (hblnk1_q || vblnk1_q) ? 12'h000 :
                   |brd1_q  ? BORDER_COLOR :
                   press_px ? PRESS_COLOR  :
                   hover_px ? HOVER_COLOR  :
                   |in1_q   ? BTN_COLOR    : rgb1_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hcount1_q <= '0;
            vcount1_q <= '0;
            hblnk1_q  <= 1'b0;
            vblnk1_q  <= 1'b0;
            hsync1_q  <= 1'b0;
            vsync1_q  <= 1'b0;
            rgb1_q    <= '0;
            in1_q     <= '0;
            brd1_q    <= '0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hcount1_q <= vga_in.hcount;
            vcount1_q <= vga_in.vcount;
            hblnk1_q  <= vga_in.hblnk;
            vblnk1_q  <= vga_in.vblnk;
            hsync1_q  <= vga_in.hsync;
            vsync1_q  <= vga_in.vsync;
            rgb1_q    <= rgb_i;
            in1_q     <= in_d;
            brd1_q    <= brd_d;
            vga_out.hcount <= hcount1_q;
            vga_out.vcount <= vcount1_q;
            vga_out.hblnk  <= hblnk1_q;
            vga_out.vblnk  <= vblnk1_q;
            vga_out.hsync  <= hsync1_q;
            vga_out.vsync  <= vsync1_q;
            rgb_q     <= rgb_d;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mx_q     <= 12'hFFF;
            my_q     <= 12'hFFF;
            ml_q     <= 1'b0;
            sample_q <= 1'b0;
            state_q  <= IDLE;
            arm_q    <= 2'd0;
        end else begin
            if (sample) begin
                mx_q <= mouse_x;
                my_q <= mouse_y;
                ml_q <= mouse_left;
            end
            sample_q <= sample;
            state_q  <= state_d;
            arm_q    <= arm_d;
        end
    // A pending selection is never overwritten; later events are dropped
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sel_valid_q <= 1'b0;
            sel_idx_q   <= 2'd0;
        end else if (sel_valid_q && sel_ready) begin
            sel_valid_q <= 1'b0;
        end else if (sel_evt && !sel_valid_q) begin
            sel_valid_q <= 1'b1;
            sel_idx_q   <= arm_q;
        end
    assign rgb_o     = rgb_q;
    assign sel_valid = sel_valid_q;
    assign sel_idx   = sel_idx_q;
endmodule
